picorv32_avalon_bridge: RTL

Converts the PicoRV32 native memory interface (`mem_valid`/`mem_ready`) into a pipelined Avalon-MM master. The master drives the SoC interconnect, and through it the on-chip FPGA RAM slave (32-bit, 1024 words, read latency 1) and the other peripherals. The bridge allows one outstanding transfer at a time. A watchdog completes any transfer the fabric fails to answer and flags it as a bus error.

---
 rtl/picorv32_avalon_bridge.sv | 122 ++++++++++++
 1 files changed

// File: rtl/picorv32_avalon_bridge.sv
// PicoRV32 native memory port to pipelined Avalon-MM master bridge.
// One transfer in flight at a time, with a watchdog that turns a silent fabric into a bus error.
module picorv32_avalon_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        bus_error,
    output logic [1:0]  dbg_state
);

    // Handshakes: the CPU holds mem_valid until a one-cycle mem_ready; an Avalon command
    // transfers on a clock edge where avm_read/avm_write is high and avm_waitrequest is low;
    // avm_readdatavalid is a single-cycle strobe honoured only while a read response is awaited.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic        is_write;
    logic        err_q;
    logic        busy;
    logic        timeout;
    logic        accept;
    logic        rsp;
    logic        unused_ok;

    assign unused_ok = ^{mem_instr, mem_addr[1:0]};

    assign busy    = (state == S_REQ) || (state == S_WAIT);
    // Fires on the TIMEOUT_CYCLES-th busy cycle and beats any same-cycle acceptance or response.
    assign timeout = busy && (cnt == TO_LAST);
    assign accept  = (state == S_REQ) && !avm_waitrequest;
    assign rsp     = (state == S_WAIT) && avm_readdatavalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (mem_valid) state_next = S_REQ;
            S_REQ: begin
                if (timeout)     state_next = S_DONE;
                else if (accept) state_next = is_write ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (timeout || rsp) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read  = (state == S_REQ) && !is_write;
        avm_write = (state == S_REQ) && is_write;
        mem_ready = (state == S_DONE);
        bus_error = (state == S_DONE) && err_q;
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address    <= 32'd0;
            avm_byteenable <= 4'd0;
            avm_writedata  <= 32'd0;
            is_write       <= 1'b0;
            err_q          <= 1'b0;
            cnt            <= 16'd0;
            mem_rdata      <= 32'd0;
        end else begin
            if (state == S_IDLE && mem_valid) begin
                avm_address    <= {mem_addr[31:2], 2'b00};
                avm_byteenable <= (mem_wstrb == 4'd0) ? 4'hF : mem_wstrb;
                avm_writedata  <= mem_wdata;
                is_write       <= (mem_wstrb != 4'd0);
                err_q          <= 1'b0;
                cnt            <= 16'd0;
            end
            if (busy) begin
                cnt <= cnt + 16'd1;
            end
            if (timeout) begin
                err_q <= 1'b1;
                if (!is_write) mem_rdata <= ERR_RDATA;
            end else if (rsp) begin
                mem_rdata <= avm_readdata;
            end
        end
    end

endmodule
